led_pwm_driver: RTL

Downstream LED output stage. Accepts mode/brightness commands over a valid/ready handshake and drives a single LED pin with a glitch-free PWM waveform. Supported modes are off, solid, blink and, optionally, breathe. It sits between the `top` control logic and the physical `led` pad. New commands only take effect on PWM period boundaries.

---
 rtl/led_pkg.sv | 36 +++
 rtl/led_pwm_driver_tick_gen.sv | 31 +++
 rtl/led_pwm_driver.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared types for the LED PWM output stage.
// The command level field is sized for the widest supported PWM (16 bits);
// narrower configurations zero-extend their level into it.
`timescale 1ns/1ps
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  localparam int LED_LEVEL_W = 16;

  typedef struct packed {
    led_mode_e                mode;
    logic [LED_LEVEL_W-1:0]   level;
  } led_cmd_t;

  localparam led_cmd_t LED_CMD_IDLE = '{mode: MODE_OFF, level: {LED_LEVEL_W{1'b0}}};

  // Map the raw two-bit mode field onto the mode enumeration.
  function automatic led_mode_e decode_mode(input logic [1:0] raw);
    led_mode_e m;
    case (raw)
      2'd0:    m = MODE_OFF;
      2'd1:    m = MODE_SOLID;
      2'd2:    m = MODE_BLINK;
      2'd3:    m = MODE_BREATHE;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/led_pwm_driver_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every CLK_DIV clocks.
// The tick is a decode of the counter state, so it is high in the cycle
// the count sits at CLK_DIV-1; CLK_DIV=1 yields a permanently high tick.
`timescale 1ns/1ps
module tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running prescale counter, wrapping at CLK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: LED output stage with off/solid/blink(/breathe) modes.
// Commands are captured into a single pending slot and only become active
// on a PWM period boundary, so the waveform never glitches mid-period.
// Optional feature macro: LED_BREATHE_EN (adds the breathe ramp for mode 3;
// without it mode 3 behaves as OFF). PWM_BITS must not exceed 16.
`timescale 1ns/1ps
module led_pwm_driver #(
  parameter int CLK_DIV       = 4,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PWM_BITS-1:0] cmd_level,
  output logic                led
);

  import led_pkg::*;

  localparam int                     BW         = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BW-1:0]          BLINK_LAST = BW'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0]    PWM_MAX    = {PWM_BITS{1'b1}};
  localparam logic [LED_LEVEL_W-1:0] LEVEL_ZERO = {LED_LEVEL_W{1'b0}};
  localparam logic [LED_LEVEL_W-1:0] LEVEL_ONE  = LED_LEVEL_W'(1);

  logic                   tick_s;
  logic                   bnd_s;
  logic                   accept_s;
  logic                   apply_s;
  logic [PWM_BITS-1:0]    pwm_cnt_r;
  logic                   cmd_ready_r;
  led_cmd_t               pend_r;
  led_cmd_t               act_r;
  logic [BW-1:0]          blink_cnt_r;
  logic                   blink_on_r;
  logic [LED_LEVEL_W-1:0] duty_s;
  logic                   led_r;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // The pending slot is full exactly when cmd_ready is low.
  assign bnd_s    = tick_s && (pwm_cnt_r == PWM_MAX);
  assign accept_s = cmd_valid && cmd_ready_r;
  assign apply_s  = bnd_s && !cmd_ready_r;

  // PWM period counter, advanced by the prescaler tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_r <= {PWM_BITS{1'b0}};
    end else if (tick_s) begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Handshake flag: drops after an accept, returns after the apply boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
    end else if (apply_s) begin
      cmd_ready_r <= 1'b1;
    end else if (accept_s) begin
      cmd_ready_r <= 1'b0;
    end else begin
      cmd_ready_r <= cmd_ready_r;
    end
  end

  // Pending command capture; payload is ignored while the slot is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= LED_CMD_IDLE;
    end else if (accept_s) begin
      pend_r.mode  <= decode_mode(cmd_mode);
      pend_r.level <= LED_LEVEL_W'(cmd_level);
    end else begin
      pend_r <= pend_r;
    end
  end

  // Active command, replaced only on a boundary with a pending command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_r <= LED_CMD_IDLE;
    end else if (apply_s) begin
      act_r <= pend_r;
    end else begin
      act_r <= act_r;
    end
  end

  // Blink phase: toggles every BLINK_PERIODS boundaries, restarts on apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_on_r  <= 1'b1;
    end else if (apply_s) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_on_r  <= 1'b1;
    end else if (bnd_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= {BW{1'b0}};
        blink_on_r  <= ~blink_on_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
        blink_on_r  <= blink_on_r;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_on_r  <= blink_on_r;
    end
  end

`ifdef LED_BREATHE_EN
  logic [LED_LEVEL_W-1:0] br_duty_r;
  logic                   br_up_r;

  // Breathe ramp: one step per boundary, bouncing between 0 and the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_duty_r <= LEVEL_ZERO;
      br_up_r   <= 1'b1;
    end else if (apply_s) begin
      br_duty_r <= LEVEL_ZERO;
      br_up_r   <= 1'b1;
    end else if (bnd_s && (act_r.mode == MODE_BREATHE)) begin
      if (act_r.level == LEVEL_ZERO) begin
        br_duty_r <= LEVEL_ZERO;
        br_up_r   <= 1'b1;
      end else if (br_up_r) begin
        if (br_duty_r < act_r.level) begin
          br_duty_r <= br_duty_r + LEVEL_ONE;
          br_up_r   <= 1'b1;
        end else begin
          br_duty_r <= br_duty_r - LEVEL_ONE;
          br_up_r   <= 1'b0;
        end
      end else begin
        if (br_duty_r != LEVEL_ZERO) begin
          br_duty_r <= br_duty_r - LEVEL_ONE;
          br_up_r   <= 1'b0;
        end else begin
          br_duty_r <= br_duty_r + LEVEL_ONE;
          br_up_r   <= 1'b1;
        end
      end
    end else begin
      br_duty_r <= br_duty_r;
      br_up_r   <= br_up_r;
    end
  end
`endif

  // Effective duty selection from the active mode.
  always_comb begin
    duty_s = LEVEL_ZERO;
    case (act_r.mode)
      MODE_OFF:   duty_s = LEVEL_ZERO;
      MODE_SOLID: duty_s = act_r.level;
      MODE_BLINK: begin
        if (blink_on_r) begin
          duty_s = act_r.level;
        end else begin
          duty_s = LEVEL_ZERO;
        end
      end
`ifdef LED_BREATHE_EN
      MODE_BREATHE: duty_s = br_duty_r;
`else
      MODE_BREATHE: duty_s = LEVEL_ZERO;
`endif
      default:    duty_s = LEVEL_ZERO;
    endcase
  end

  // Registered PWM compare; level 2^N-1 never reaches 100 % by design.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r <= 1'b0;
    end else begin
      led_r <= (LED_LEVEL_W'(pwm_cnt_r) < duty_s);
    end
  end

  assign led       = led_r;
  assign cmd_ready = cmd_ready_r;

endmodule
